// File: rtl/coin_credit.sv
// Coin-credit vending controller: synchronised, debounced buttons feeding an IDLE/VEND/CHANGE FSM.
// Press-to-event ~2+DEBOUNCE_CYCLES cycles, result pulses one cycle later; no backpressure, coins outside IDLE are rejected.
module coin_credit #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_CREDIT      = 995
) (
    input  logic       clk_fast,
    input  logic       rst_n,
    input  logic       btn_dollar,
    input  logic       btn_quarter,
    input  logic       btn_dime,
    input  logic       btn_nickel,
    input  logic       btn_buy,
    input  logic       btn_return,
    input  logic [7:0] sw,
    output logic       dollar,
    output logic       quarter,
    output logic       dime,
    output logic       nickel,
    output logic       credit,
    output logic [9:0] credit_cents,
    output logic       vend,
    output logic       deny,
    output logic       reject,
    output logic       chg_quarter,
    output logic       chg_dime,
    output logic       chg_nickel,
    output logic       busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] VEND   = 2'd1;
    localparam logic [1:0] CHANGE = 2'd2;

    // Bit order: 0 nickel, 1 dime, 2 quarter, 3 dollar, 4 buy, 5 return
    logic [5:0] btn_raw;
    logic [5:0] sync1;
    logic [5:0] sync2;
    logic [5:0] db_lvl;
    logic [5:0] db_prev;
    logic [5:0] ev;

    assign btn_raw = {btn_return, btn_buy, btn_dollar, btn_quarter, btn_dime, btn_nickel};

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            db_prev <= '0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            db_prev <= db_lvl;
        end
    end

    for (genvar i = 0; i < 6; i++) begin : g_db
        logic [CW-1:0] cnt;
        logic          lvl;

        // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts it.
        always_ff @(posedge clk_fast or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync2[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt <= '0;
                lvl <= sync2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign db_lvl[i] = lvl;
    end

    assign ev = db_lvl & ~db_prev;

    logic [1:0]  state, state_n;
    logic [9:0]  credit_n;
    logic [9:0]  price_q, price_n;
    logic [10:0] price;
    logic [10:0] sum;
    logic [10:0] coin_val;
    logic [9:0]  rem;
    logic        coin_any, coin_multi;
    logic        dollar_n, quarter_n, dime_n, nickel_n;
    logic        vend_n, deny_n, reject_n;
    logic        chg_quarter_n, chg_dime_n, chg_nickel_n;

    assign price      = {3'b000, sw} * 11'd5;
    assign coin_any   = |ev[3:0];
    assign coin_multi = (ev[3:0] & (ev[3:0] - 4'd1)) != 4'd0;

    always_comb begin
        state_n       = state;
        credit_n      = credit_cents;
        price_n       = price_q;
        dollar_n      = 1'b0;
        quarter_n     = 1'b0;
        dime_n        = 1'b0;
        nickel_n      = 1'b0;
        vend_n        = 1'b0;
        deny_n        = 1'b0;
        reject_n      = 1'b0;
        chg_quarter_n = 1'b0;
        chg_dime_n    = 1'b0;
        chg_nickel_n  = 1'b0;
        coin_val      = 11'd0;
        sum           = 11'd0;
        rem           = 10'd0;
        case (state)
            IDLE: begin
                if (ev[4]) begin
                    reject_n = coin_any;
                    if (sw == 8'd0 || {1'b0, credit_cents} < price) begin
                        deny_n = 1'b1;
                    end else begin
                        state_n = VEND;
                        vend_n  = 1'b1;
                        price_n = price[9:0];
                    end
                end else if (ev[5]) begin
                    reject_n = coin_any;
                    if (credit_cents != 10'd0) state_n = CHANGE;
                end else if (coin_any) begin
                    if (ev[3])      coin_val = 11'd100;
                    else if (ev[2]) coin_val = 11'd25;
                    else if (ev[1]) coin_val = 11'd10;
                    else            coin_val = 11'd5;
                    sum = {1'b0, credit_cents} + coin_val;
                    if (sum > 11'(MAX_CREDIT)) begin
                        reject_n = 1'b1;
                    end else begin
                        credit_n  = sum[9:0];
                        dollar_n  = ev[3];
                        quarter_n = ~ev[3] & ev[2];
                        dime_n    = ~ev[3] & ~ev[2] & ev[1];
                        nickel_n  = ~ev[3] & ~ev[2] & ~ev[1];
                        reject_n  = coin_multi;
                    end
                end
            end
            VEND: begin
                reject_n = coin_any;
                rem      = credit_cents - price_q;
                credit_n = rem;
                state_n  = (rem != 10'd0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_n = coin_any;
                if (credit_cents >= 10'd25) begin
                    chg_quarter_n = 1'b1;
                    credit_n      = credit_cents - 10'd25;
                end else if (credit_cents >= 10'd10) begin
                    chg_dime_n = 1'b1;
                    credit_n   = credit_cents - 10'd10;
                end else if (credit_cents >= 10'd5) begin
                    chg_nickel_n = 1'b1;
                    credit_n     = credit_cents - 10'd5;
                end else begin
                    credit_n = 10'd0;
                end
                if (credit_n == 10'd0) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            credit_cents <= '0;
            price_q      <= '0;
            dollar       <= 1'b0;
            quarter      <= 1'b0;
            dime         <= 1'b0;
            nickel       <= 1'b0;
            vend         <= 1'b0;
            deny         <= 1'b0;
            reject       <= 1'b0;
            chg_quarter  <= 1'b0;
            chg_dime     <= 1'b0;
            chg_nickel   <= 1'b0;
        end else begin
            state        <= state_n;
            credit_cents <= credit_n;
            price_q      <= price_n;
            dollar       <= dollar_n;
            quarter      <= quarter_n;
            dime         <= dime_n;
            nickel       <= nickel_n;
            vend         <= vend_n;
            deny         <= deny_n;
            reject       <= reject_n;
            chg_quarter  <= chg_quarter_n;
            chg_dime     <= chg_dime_n;
            chg_nickel   <= chg_nickel_n;
        end
    end

    assign credit = (state == IDLE) && (credit_cents != 10'd0);
    assign busy   = (state == VEND) || (state == CHANGE);

endmodule

// File: tb/tb_coin_credit.sv
// Randomised bench for coin_credit against a transaction-level credit/pulse model.
module tb_coin_credit;

    localparam int MAXC   = 995;
    localparam int HOLD   = 30;
    localparam int SETTLE = 80;

    localparam logic [5:0] B_NIC = 6'b000001;
    localparam logic [5:0] B_DIM = 6'b000010;
    localparam logic [5:0] B_QTR = 6'b000100;
    localparam logic [5:0] B_DOL = 6'b001000;
    localparam logic [5:0] B_BUY = 6'b010000;
    localparam logic [5:0] B_RET = 6'b100000;

    localparam int C_DOL = 1, C_QTR = 2, C_DIM = 3, C_NIC = 4, C_REJ = 5;
    localparam int C_VND = 6, C_DEN = 7, C_CHQ = 8, C_CHD = 9, C_CHN = 10;

    logic       clk_fast = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_dollar = 1'b0, btn_quarter = 1'b0, btn_dime = 1'b0, btn_nickel = 1'b0;
    logic       btn_buy = 1'b0, btn_return = 1'b0;
    logic [7:0] sw = 8'd0;
    logic       dollar, quarter, dime, nickel, credit, vend, deny, reject;
    logic       chg_quarter, chg_dime, chg_nickel, busy;
    logic [9:0] credit_cents;

    int n_chk = 0;
    int n_fail = 0;
    int excl_viol = 0;
    int m_credit = 0;
    int obs_q[$];
    int exp_q[$];

    coin_credit dut (
        .clk_fast(clk_fast), .rst_n(rst_n),
        .btn_dollar(btn_dollar), .btn_quarter(btn_quarter), .btn_dime(btn_dime),
        .btn_nickel(btn_nickel), .btn_buy(btn_buy), .btn_return(btn_return), .sw(sw),
        .dollar(dollar), .quarter(quarter), .dime(dime), .nickel(nickel),
        .credit(credit), .credit_cents(credit_cents), .vend(vend), .deny(deny),
        .reject(reject), .chg_quarter(chg_quarter), .chg_dime(chg_dime),
        .chg_nickel(chg_nickel), .busy(busy)
    );

    always #5 clk_fast = ~clk_fast;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse log in a fixed per-cycle order; the model pushes in the same order.
    always @(negedge clk_fast) begin
        if (rst_n) begin
            if (dollar)      obs_q.push_back(C_DOL);
            if (quarter)     obs_q.push_back(C_QTR);
            if (dime)        obs_q.push_back(C_DIM);
            if (nickel)      obs_q.push_back(C_NIC);
            if (reject)      obs_q.push_back(C_REJ);
            if (vend)        obs_q.push_back(C_VND);
            if (deny)        obs_q.push_back(C_DEN);
            if (chg_quarter) obs_q.push_back(C_CHQ);
            if (chg_dime)    obs_q.push_back(C_CHD);
            if (chg_nickel)  obs_q.push_back(C_CHN);
            if (int'(dollar) + int'(quarter) + int'(dime) + int'(nickel) > 1) excl_viol++;
            if (int'(chg_quarter) + int'(chg_dime) + int'(chg_nickel) > 1) excl_viol++;
            if (vend && deny) excl_viol++;
        end
    end

    task automatic push_change(input int amount);
        int r;
        for (int i = 0; i < amount / 25; i++) exp_q.push_back(C_CHQ);
        r = amount % 25;
        for (int i = 0; i < r / 10; i++) exp_q.push_back(C_CHD);
        for (int i = 0; i < (r % 10) / 5; i++) exp_q.push_back(C_CHN);
    endtask

    task automatic model_apply(input logic [5:0] mask, input logic [7:0] swv);
        int price, v, code, ncoin;
        ncoin = int'(mask[0]) + int'(mask[1]) + int'(mask[2]) + int'(mask[3]);
        if (mask[4]) begin
            price = int'(swv) * 5;
            if (ncoin > 0) exp_q.push_back(C_REJ);
            if (swv == 8'd0 || m_credit < price) exp_q.push_back(C_DEN);
            else begin
                exp_q.push_back(C_VND);
                push_change(m_credit - price);
                m_credit = 0;
            end
        end else if (mask[5]) begin
            if (ncoin > 0) exp_q.push_back(C_REJ);
            if (m_credit > 0) begin
                push_change(m_credit);
                m_credit = 0;
            end
        end else if (ncoin > 0) begin
            if (mask[3])      begin v = 100; code = C_DOL; end
            else if (mask[2]) begin v = 25;  code = C_QTR; end
            else if (mask[1]) begin v = 10;  code = C_DIM; end
            else              begin v = 5;   code = C_NIC; end
            if (m_credit + v > MAXC) exp_q.push_back(C_REJ);
            else begin
                m_credit += v;
                exp_q.push_back(code);
                if (ncoin > 1) exp_q.push_back(C_REJ);
            end
        end
    endtask

    task automatic drive(input logic [5:0] mask);
        {btn_return, btn_buy, btn_dollar, btn_quarter, btn_dime, btn_nickel} = mask;
    endtask

    task automatic compare(input string tag);
        int n;
        chk({tag, "_npulses"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_pulse"}, obs_q[i], exp_q[i]);
        chk({tag, "_cents"}, int'(credit_cents), m_credit);
        chk({tag, "_credit"}, int'(credit), int'(m_credit != 0));
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic run_op(input string tag, input logic [5:0] mask, input logic [7:0] swv);
        obs_q.delete();
        exp_q.delete();
        sw = swv;
        model_apply(mask, swv);
        drive(mask);
        repeat (HOLD) @(posedge clk_fast);
        drive(6'b0);
        repeat (SETTLE) @(posedge clk_fast);
        @(negedge clk_fast);
        compare(tag);
    endtask

    initial begin
        logic [5:0] mask;
        logic [7:0] swv;
        int r, t, found;

        // Reset with nickel already held: one event expected once reset releases.
        btn_nickel = 1'b1;
        repeat (5) @(posedge clk_fast);
        @(negedge clk_fast);
        chk("rst_cents", int'(credit_cents), 0);
        chk("rst_credit", int'(credit), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pulses", int'({dollar, quarter, dime, nickel, vend, deny, reject,
                                chg_quarter, chg_dime, chg_nickel}), 0);
        obs_q.delete();
        exp_q.delete();
        model_apply(B_NIC, 8'd0);
        rst_n = 1'b1;
        repeat (40) @(posedge clk_fast);
        btn_nickel = 1'b0;
        repeat (SETTLE) @(posedge clk_fast);
        @(negedge clk_fast);
        compare("held_thru_rst");
        run_op("clear0", B_RET, 8'd0);

        run_op("s_qtr", B_QTR, 8'd0);
        run_op("s_dim", B_DIM, 8'd0);
        run_op("s_nic", B_NIC, 8'd0);
        run_op("clear1", B_RET, 8'd0);

        // Bouncing dime then stable
        obs_q.delete();
        exp_q.delete();
        model_apply(B_DIM, 8'd0);
        for (int i = 0; i < 30; i++) begin
            btn_dime = (i % 3 != 2);
            @(posedge clk_fast);
        end
        btn_dime = 1'b1;
        repeat (40) @(posedge clk_fast);
        btn_dime = 1'b0;
        repeat (SETTLE) @(posedge clk_fast);
        @(negedge clk_fast);
        compare("bounce");
        run_op("clear2", B_RET, 8'd0);

        // Fill to 990, then the ceiling
        for (int i = 0; i < 9; i++) run_op("fill_dol", B_DOL, 8'd0);
        for (int i = 0; i < 3; i++) run_op("fill_qtr", B_QTR, 8'd0);
        run_op("fill_dim", B_DIM, 8'd0);
        run_op("fill_nic", B_NIC, 8'd0);
        run_op("max_nic", B_NIC, 8'd0);
        run_op("max_dim_rej", B_DIM, 8'd0);
        run_op("max_ret", B_RET, 8'd0);

        run_op("buy_dol", B_DOL, 8'd0);
        run_op("buy65", B_BUY, 8'd13);

        run_op("deny_q1", B_QTR, 8'd0);
        run_op("deny_q2", B_QTR, 8'd0);
        run_op("deny_price", B_BUY, 8'd20);
        run_op("deny_sw0", B_BUY, 8'd0);
        run_op("buy_exact", B_BUY, 8'd10);

        run_op("multi_dol_dim", B_DOL | B_DIM, 8'd0);
        run_op("buy_ret", B_BUY | B_RET, 8'd4);
        run_op("ret_empty", B_RET, 8'd0);
        run_op("m_qtr", B_QTR, 8'd0);
        run_op("ret_coin", B_RET | B_NIC, 8'd0);

        // Reset mid-change drops the remaining credit
        run_op("r_qtr", B_QTR, 8'd0);
        run_op("r_dim1", B_DIM, 8'd0);
        run_op("r_dim2", B_DIM, 8'd0);
        obs_q.delete();
        exp_q.delete();
        exp_q.push_back(C_CHQ);
        btn_return = 1'b1;
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            @(negedge clk_fast);
            if (chg_quarter) found = 1;
        end
        chk("midchg_wait", found, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midchg_rst_cents", int'(credit_cents), 0);
        chk("midchg_rst_chg", int'({chg_quarter, chg_dime, chg_nickel}), 0);
        chk("midchg_rst_busy", int'(busy), 0);
        chk("midchg_rst_credit", int'(credit), 0);
        m_credit = 0;
        repeat (3) @(negedge clk_fast);
        rst_n = 1'b1;
        repeat (40) @(posedge clk_fast);
        btn_return = 1'b0;
        repeat (SETTLE) @(posedge clk_fast);
        @(negedge clk_fast);
        compare("midchg");

        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 99));
            swv = 8'($urandom_range(0, 255));
            if (r < 60) mask = B_NIC << $urandom_range(0, 3);
            else if (r < 70) mask = 6'($urandom_range(1, 15));
            else if (r < 85) begin
                if ($urandom_range(0, 1) == 1) begin
                    t = m_credit / 5 + 1 - int'($urandom_range(0, 3));
                    if (t < 0) t = 0;
                    if (t > 255) t = 255;
                    swv = 8'(t);
                end
                mask = B_BUY;
                if ($urandom_range(0, 4) == 0) mask = mask | (B_NIC << $urandom_range(0, 3));
            end else if (r < 95) begin
                mask = B_RET;
                if ($urandom_range(0, 3) == 0) mask = mask | (B_NIC << $urandom_range(0, 3));
            end else mask = B_BUY | B_RET;
            run_op("rand", mask, swv);
        end

        chk("exclusive_pulses", excl_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_credit.md
COIN_CREDIT -- requirements
Module: coin_credit

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of consecutive stable synchronized samples required before a button level is accepted.
REQ-002 The block SHALL have parameter MAX_CREDIT, default 995, the credit ceiling in cents (a multiple of 5).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk_fast, input, 1: system clock; all state on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Ports btn_dollar, btn_quarter, btn_dime, btn_nickel, input, 1 each: raw, asynchronous coin buttons.
REQ-007 Ports btn_buy and btn_return, input, 1 each: raw, asynchronous purchase and refund buttons.
REQ-008 Port sw, input, 8: item price in nickels, where price_cents = sw*5; sw==0 means no item selected.
REQ-009 Ports dollar, quarter, dime, nickel, output, 1 each: one-cycle pulse per accepted coin, feeding the display.
REQ-010 Port credit, output, 1: high when credit_cents != 0 and the state is IDLE.
REQ-011 Port credit_cents, output, 10: current credit in binary cents.
REQ-012 Ports vend and deny, output, 1 each: one-cycle purchase result pulses.
REQ-013 Port reject, output, 1: one-cycle pulse when a debounced coin press is refused.
REQ-014 Ports chg_quarter, chg_dime, chg_nickel, output, 1 each: one-cycle change-dispense pulses.
REQ-015 Port busy, output, 1: high in the VEND and CHANGE states.

Function
REQ-016 Each button SHALL pass through a 2-flop synchronizer and then a debounce counter.
REQ-017 The debounced level SHALL change only after DEBOUNCE_CYCLES consecutive identical synchronized samples; any differing sample SHALL restart the count.
REQ-018 A press event SHALL be a single-cycle pulse on the debounced 0->1 edge; holding a button SHALL produce exactly one event.
REQ-019 The latency from a stable raw press to its event SHALL be 2 + DEBOUNCE_CYCLES cycles, ±1.
REQ-020 The FSM SHALL have the states IDLE, VEND and CHANGE.
REQ-021 In IDLE, a coin event SHALL add 100, 25, 10 or 5 cents to credit_cents on the next edge and pulse the matching coin output in that same cycle.
REQ-022 A coin SHALL be rejected (reject pulse, credit unchanged, no coin pulse) when credit_cents + value > MAX_CREDIT.
REQ-023 When coin events coincide, only the highest-value coin SHALL be evaluated (dollar > quarter > dime > nickel); the others SHALL be dropped and reject SHALL pulse.
REQ-024 Coin events arriving in VEND or CHANGE SHALL be rejected.
REQ-025 In IDLE, a buy event with sw==0 or credit_cents < sw*5 SHALL pulse deny for one cycle and leave the state IDLE.
REQ-026 In IDLE, a buy event otherwise SHALL go to VEND.
REQ-027 Arithmetic SHALL use 11-bit intermediates; sw*5 SHALL be compared unsaturated.
REQ-028 VEND SHALL last one cycle: vend pulses, credit_cents -= sw*5, sw is sampled at the buy event, next state is CHANGE if the remainder > 0, else IDLE.
REQ-029 In IDLE, a return event with credit_cents > 0 SHALL go to CHANGE; with credit_cents == 0 it SHALL be ignored.
REQ-030 When buy and return coincide, buy SHALL win.
REQ-031 A buy or return coinciding with a coin SHALL be processed and the coin rejected.
REQ-032 In CHANGE, exactly one coin SHALL be dispensed per cycle, greedy: chg_quarter (-25) if ≥25, else chg_dime (-10) if ≥10, else chg_nickel (-5).
REQ-033 The transition from CHANGE to IDLE SHALL occur on the edge at which credit_cents reaches 0.
REQ-034 Buy and return events in VEND or CHANGE SHALL be ignored.
REQ-035 All pulse outputs SHALL be registered and mutually exclusive within their group.

Reset
REQ-036 While rst_n==0, all of the following SHALL hold immediately, independent of the clock: state=IDLE, credit_cents=0, every pulse output 0, credit=0, busy=0, synchronizers and debounced levels 0, debounce counters 0.
REQ-037 Reset asserted mid-CHANGE SHALL abort dispensing and lose the remaining credit.
REQ-038 After deassertion, a button already held high SHALL produce one event after the debounce time.

Verification
REQ-039 Scenario: press quarter, then dime, then nickel, each held 40 cycles -> quarter, dime and nickel pulse once each; credit_cents = 40; credit = 1.
REQ-040 Scenario: btn_dime bouncing with a 3-cycle period for 30 cycles, then stable for 40 -> exactly one dime pulse; credit_cents = 10.
REQ-041 Scenario: credit 990, press nickel, then dime -> credit_cents = 995 after the nickel; the dime is rejected; credit_cents stays 995.
REQ-042 Scenario: credit 100, sw = 13 (65c), buy -> vend at 1 cycle, remainder 35 -> chg_quarter, then chg_dime on consecutive cycles -> IDLE; credit_cents = 0.
REQ-043 Scenario: credit 50, sw = 20 (100c), buy -> deny pulse; credit_cents = 50; state IDLE; then sw = 0, buy -> deny pulse.
REQ-044 Scenario: credit 45, return; rst_n pulsed low after the first chg_quarter -> outputs immediately 0; credit_cents = 0; no further change pulses.
